// File: rtl/stlatch_pkg.sv
// Shared defaults and pointer helpers for the stlatch_fifo staging queue.
// Optional transparent empty-queue bypass is enabled with STLATCH_BYPASS_EN.
package stlatch_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 4;

    function automatic int ptr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    // Modulo increment; DEPTH is a power of two so this is a plain wrap.
    function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
        return (ptr + 1) % depth;
    endfunction

endpackage

// File: rtl/stlatch_mem.sv
// DEPTH x WIDTH register array: one clocked write port, one asynchronous read port.
// Contents are deliberately not reset.
module stlatch_mem #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/stlatch_fifo.sv
// Multi-entry successor to the enable-latch staging register; d1 shows the head word or the last popped word.
// Define STLATCH_BYPASS_EN for the transparent d -> d1 path while the queue is empty.
module stlatch_fifo
    import stlatch_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int AW    = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             resetl,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    input  logic             rd,
    output logic [WIDTH-1:0] d1,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      level,
    output logic             ovf
);

    // en: producer strobe, d captured on the edge unless full (full & rd lets it in);
    // rd: consumer strobe, head consumed on the edge when not empty. No back-pressure wires.
    localparam logic [AW:0] LEVEL_ONE  = (AW+1)'(1);
    localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] rdata;
    logic             do_write, do_pop, do_bypass;

    assign empty = (level_q == '0);
    assign full  = (level_q == LEVEL_FULL);
    assign level = level_q;
    assign ovf   = ovf_q;

`ifdef STLATCH_BYPASS_EN
    assign do_bypass = empty & en & rd;
`else
    assign do_bypass = 1'b0;
`endif

    assign do_write = en & (~full | rd) & ~do_bypass;
    assign do_pop   = rd & ~empty;

    stlatch_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (do_write & resetl),
        .waddr (wr_ptr_q),
        .wdata (d),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        hold_d   = hold_q;
        ovf_d    = ovf_q;

        if (do_write) begin
            wr_ptr_d = AW'(next_ptr(32'(wr_ptr_q), DEPTH));
        end
        if (do_pop) begin
            rd_ptr_d = AW'(next_ptr(32'(rd_ptr_q), DEPTH));
            hold_d   = rdata;
        end
        if (do_bypass) begin
            hold_d = d;
        end

        case ({do_write, do_pop})
            2'b10:   level_d = level_q + LEVEL_ONE;
            2'b01:   level_d = level_q - LEVEL_ONE;
            default: level_d = level_q;
        endcase

        if (en && full && !rd) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetl) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            hold_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            hold_q   <= hold_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        d1 = empty ? hold_q : rdata;
`ifdef STLATCH_BYPASS_EN
        if (empty && en) begin
            d1 = d;
        end
`endif
    end

endmodule

// File: tb/tb_stlatch_fifo.sv
// Directed and random checks of stlatch_fifo against a queue-based reference model.
// Honours STLATCH_BYPASS_EN so the same bench covers both builds.
module tb_stlatch_fifo;

    localparam int W     = 16;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

`ifdef STLATCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetl;
    logic [W-1:0]  d;
    logic          en;
    logic          rd;
    logic [W-1:0]  d1;
    logic          empty;
    logic          full;
    logic [LW-1:0] level;
    logic          ovf;

    int vectors     = 0;
    int miscompares = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_hold;
    logic         m_ovf;
    bit           m_known = 1'b0;

    stlatch_fifo #(.WIDTH(W), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .resetl (resetl),
        .d      (d),
        .en     (en),
        .rd     (rd),
        .d1     (d1),
        .empty  (empty),
        .full   (full),
        .level  (level),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model_d1();
        if (exp_q.size() > 0) return exp_q[0];
        if (BYP && en === 1'b1 && resetl === 1'b1) return d;
        return m_hold;
    endfunction

    task automatic model_clock(input bit r, input bit e, input bit p, input logic [W-1:0] dv);
        if (!r) begin
            exp_q.delete();
            m_hold  = '0;
            m_ovf   = 1'b0;
            m_known = 1'b1;
            return;
        end
        if (BYP && exp_q.size() == 0 && e && p) begin
            m_hold = dv;
            return;
        end
        if (p && exp_q.size() > 0) m_hold = exp_q.pop_front();
        if (e) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(dv);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic chk_w(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        chk_w({tag, ".d1"}, d1, model_d1());
        chk_w({tag, ".empty"}, W'(empty), W'(exp_q.size() == 0));
        chk_w({tag, ".full"}, W'(full), W'(exp_q.size() == DEPTH));
        chk_w({tag, ".level"}, W'(level), W'(exp_q.size()));
        chk_w({tag, ".ovf"}, W'(ovf), W'(m_ovf));
    endtask

    // Called just after a falling edge: drive, check d1 combinationally, clock, check state.
    task automatic step(input string tag, input bit r, input bit e, input bit p, input logic [W-1:0] dv);
        resetl = r;
        en     = e;
        rd     = p;
        d      = dv;
        #1;
        if (m_known && r) chk_w({tag, ".pre_d1"}, d1, model_d1());
        @(posedge clk);
        model_clock(r, e, p, dv);
        #1;
        en = 1'b0;
        rd = 1'b0;
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    initial begin
        resetl = 1'b0;
        en     = 1'b0;
        rd     = 1'b0;
        d      = '0;
        @(negedge clk);

        // Reset then idle
        step("reset", 1'b0, 1'b0, 1'b0, '0);
        chk_w("reset.d1_zero", d1, 16'h0000);
        step("idle", 1'b1, 1'b0, 1'b0, '0);

        // Fill to full, then drain in order
        step("wr1", 1'b1, 1'b1, 1'b0, 16'h1111);
        chk_w("wr1.latency", d1, 16'h1111);
        step("wr2", 1'b1, 1'b1, 1'b0, 16'h2222);
        step("wr3", 1'b1, 1'b1, 1'b0, 16'h3333);
        step("wr4", 1'b1, 1'b1, 1'b0, 16'h4444);
        chk_w("wr4.full", W'(full), W'(1));
        for (int i = 0; i < 4; i++) step("drain", 1'b1, 1'b0, 1'b1, '0);
        chk_w("drain.hold", d1, 16'h4444);
        step("rd_empty", 1'b1, 1'b0, 1'b1, '0);
        chk_w("rd_empty.hold", d1, 16'h4444);

        // Overflow while full, then simultaneous write+pop at full
        for (int i = 1; i <= 4; i++) step("refill", 1'b1, 1'b1, 1'b0, W'(i * 16'h1111));
        step("ovf", 1'b1, 1'b1, 1'b0, 16'h5555);
        chk_w("ovf.flag", W'(ovf), W'(1));
        step("wr_rd_full", 1'b1, 1'b1, 1'b1, 16'h6666);
        chk_w("wr_rd_full.d1", d1, 16'h2222);
        for (int i = 0; i < 4; i++) step("drain2", 1'b1, 1'b0, 1'b1, '0);
        chk_w("drain2.last", d1, 16'h6666);

        // Wrap: interleaved write/pop pairs
        for (int i = 1; i <= 10; i++) begin
            step("wrap_wr", 1'b1, 1'b1, 1'b0, W'(i));
            step("wrap_rd", 1'b1, 1'b0, 1'b1, '0);
        end
        chk_w("wrap.last", d1, 16'd10);

        // Empty queue with en & rd together
        step("byp", 1'b1, 1'b1, 1'b1, 16'hABCD);
        chk_w("byp.d1", d1, 16'hABCD);
        chk_w("byp.level", W'(level), BYP ? W'(0) : W'(1));

        // Reset mid-operation discards the concurrent write
        step("rst_pre", 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) step("rst_fill", 1'b1, 1'b1, 1'b0, W'($urandom));
        step("rst_mid", 1'b0, 1'b1, 1'b0, 16'hBEEF);
        chk_w("rst_mid.level", W'(level), W'(0));
        chk_w("rst_mid.d1", d1, 16'h0000);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom_range(0, 59) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), W'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
